// File: rtl/pause_fade_ctrl.sv
// Merges user/OSD/request pause sources into pause_cpu and fades the RGB bus while user pause is held.
// Optional macro PAUSE_FRAME_ALIGN_EN: pause_cpu updates only on the cycle after a vblank rising edge.
module pause_fade_ctrl #(
   parameter int RW            = 3,
   parameter int GW            = 3,
   parameter int BW            = 2,
   parameter int NREQ          = 1,
   parameter int TICKS_PER_SEC = 20_000_000,
   parameter int DIM_SECONDS   = 10,
   parameter int FADE_CYCLES   = 2_000_000,
   parameter int DIM_MAX       = 2
) (
   input  logic                           clk_sys,
   input  logic                           reset,
   input  logic                           user_button,
   input  logic [NREQ-1:0]                pause_request,
   input  logic                           OSD_STATUS,
   input  logic [1:0]                     options,
   input  logic                           vblank,
   input  logic [RW-1:0]                  r,
   input  logic [GW-1:0]                  g,
   input  logic [BW-1:0]                  b,
   output logic [RW+GW+BW-1:0]            rgb_out,
   output logic                           pause_cpu,
   output logic [$clog2(DIM_MAX+1)-1:0]   dim_level
);

   localparam int          LW        = $clog2(DIM_MAX + 1);
   localparam logic [31:0] DIM_TERM  = 32'(TICKS_PER_SEC * DIM_SECONDS - 1);
   localparam logic [31:0] FADE_TERM = 32'(FADE_CYCLES - 1);
   localparam logic [LW-1:0] LEVEL_MAX = LW'(DIM_MAX);

   typedef enum logic [1:0] {
      S_RUN,
      S_PAUSED,
      S_FADING,
      S_DIMMED
   } state_t;

   state_t        state_reg, state_next;
   logic [31:0]   dim_timer_reg, dim_timer_next;
   logic [31:0]   fade_timer_reg, fade_timer_next;
   logic [LW-1:0] dim_level_reg, dim_level_next;
   logic [LW-1:0] level_inc;
   logic          btn_prev_reg;
   logic          opt1_prev_reg;
   logic          toggle_reg;
   logic          btn_edge;
   logic          toggle_eff;
   logic          dim_fall;
   logic          pause_src;
   logic          pause_load;

   assign btn_edge   = user_button & ~btn_prev_reg;
   // The toggle's next value drives the FSM so a button edge beats a same-cycle timer terminal count.
   assign toggle_eff = toggle_reg ^ btn_edge;
   assign dim_fall   = opt1_prev_reg & ~options[1];
   assign pause_src  = toggle_reg | (|pause_request) | (OSD_STATUS & options[0]);
   assign level_inc  = dim_level_reg + LW'(1);
   assign dim_level  = dim_level_reg;

`ifdef PAUSE_FRAME_ALIGN_EN
   logic vblank_prev_reg;

   always_ff @(posedge clk_sys) begin
      vblank_prev_reg <= vblank;
   end

   assign pause_load = vblank & ~vblank_prev_reg;
`else
   logic unused_vblank;

   assign unused_vblank = vblank;
   assign pause_load    = 1'b1;
`endif

   always_comb begin
      state_next      = state_reg;
      dim_timer_next  = dim_timer_reg;
      fade_timer_next = fade_timer_reg;
      dim_level_next  = dim_level_reg;
      if (!toggle_eff || dim_fall) begin
         state_next      = S_RUN;
         dim_level_next  = '0;
         dim_timer_next  = '0;
         fade_timer_next = '0;
      end else begin
         case (state_reg)
            S_RUN: begin
               state_next     = S_PAUSED;
               dim_timer_next = '0;
            end
            S_PAUSED: begin
               if (options[1]) begin
                  if (dim_timer_reg == DIM_TERM) begin
                     fade_timer_next = '0;
                     dim_level_next  = LW'(1);
                     state_next      = (DIM_MAX == 1) ? S_DIMMED : S_FADING;
                  end else if (dim_timer_reg != '1) begin
                     dim_timer_next = dim_timer_reg + 32'd1;
                  end
               end
            end
            S_FADING: begin
               if (fade_timer_reg == FADE_TERM) begin
                  fade_timer_next = '0;
                  dim_level_next  = level_inc;
                  if (level_inc == LEVEL_MAX) begin
                     state_next = S_DIMMED;
                  end
               end else if (fade_timer_reg != '1) begin
                  fade_timer_next = fade_timer_reg + 32'd1;
               end
            end
            S_DIMMED: begin
               dim_level_next = LEVEL_MAX;
            end
            default: begin
               state_next     = S_RUN;
               dim_level_next = '0;
            end
         endcase
      end
   end

   // Edge-detect history tracks the inputs even in reset so a level held through reset never fires.
   always_ff @(posedge clk_sys) begin
      btn_prev_reg  <= user_button;
      opt1_prev_reg <= options[1];
      if (reset) begin
         toggle_reg     <= 1'b0;
         state_reg      <= S_RUN;
         dim_timer_reg  <= '0;
         fade_timer_reg <= '0;
         dim_level_reg  <= '0;
         pause_cpu      <= 1'b0;
         rgb_out        <= '0;
      end else begin
         toggle_reg     <= toggle_eff;
         state_reg      <= state_next;
         dim_timer_reg  <= dim_timer_next;
         fade_timer_reg <= fade_timer_next;
         dim_level_reg  <= dim_level_next;
         if (pause_load) begin
            pause_cpu <= pause_src;
         end
         rgb_out <= {r >> dim_level_reg, g >> dim_level_reg, b >> dim_level_reg};
      end
   end

endmodule

// File: tb/tb_pause_fade_ctrl.sv
// Bench for pause_fade_ctrl: directed steps followed by random stimulus against a level-from-count model.
module tb_pause_fade_ctrl;

   localparam int TPS = 10;
   localparam int DSEC = 2;
   localparam int FC = 4;
   localparam int DMAX = 2;
   localparam int TERM = TPS * DSEC;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       user_button = 1'b0;
   logic [0:0] pause_request = 1'b0;
   logic       OSD_STATUS = 1'b0;
   logic [1:0] options = 2'b00;
   logic       vblank = 1'b0;
   logic [2:0] r = 3'd7;
   logic [2:0] g = 3'd7;
   logic [1:0] b = 2'd3;
   logic [7:0] rgb_out;
   logic       pause_cpu;
   logic [1:0] dim_level;

   int compared = 0;
   int mismatched = 0;

   // reference model state
   bit         m_toggle = 0;
   bit         m_btn_prev = 0;
   bit         m_opt1_prev = 0;
   bit         m_vb_prev = 0;
   bit         m_paused = 0;
   int         m_count = 0;
   int         m_level = 0;
   logic [7:0] m_rgb = '0;
   bit         m_pause = 0;

   pause_fade_ctrl #(
      .RW(3), .GW(3), .BW(2), .NREQ(1),
      .TICKS_PER_SEC(TPS), .DIM_SECONDS(DSEC), .FADE_CYCLES(FC), .DIM_MAX(DMAX)
   ) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .user_button(user_button),
      .pause_request(pause_request),
      .OSD_STATUS(OSD_STATUS),
      .options(options),
      .vblank(vblank),
      .r(r),
      .g(g),
      .b(b),
      .rgb_out(rgb_out),
      .pause_cpu(pause_cpu),
      .dim_level(dim_level)
   );

   always #5 clk_sys = ~clk_sys;

   // Fade level as a function of how many dim-enabled paused cycles have elapsed.
   function automatic int level_of(input int c);
      int l;
      if (c < TERM) return 0;
      l = 1 + (c - TERM) / FC;
      return (l > DMAX) ? DMAX : l;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      bit edge_b, fall, src, tog;
      edge_b = user_button && !m_btn_prev;
      fall   = m_opt1_prev && !options[1];
      src    = m_toggle || (|pause_request) || (OSD_STATUS && options[0]);
      if (reset) begin
         m_toggle = 0;
         m_paused = 0;
         m_count  = 0;
         m_rgb    = '0;
         m_pause  = 0;
      end else begin
         m_rgb = {r >> m_level, g >> m_level, b >> m_level};
`ifdef PAUSE_FRAME_ALIGN_EN
         if (vblank && !m_vb_prev) m_pause = src;
`else
         m_pause = src;
`endif
         tog = m_toggle ^ edge_b;
         m_toggle = tog;
         if (!tog || fall) begin
            m_paused = 0;
            m_count  = 0;
         end else if (!m_paused) begin
            m_paused = 1;
            m_count  = 0;
         end else if (options[1]) begin
            m_count++;
         end
      end
      m_level     = m_paused ? level_of(m_count) : 0;
      m_btn_prev  = user_button;
      m_opt1_prev = options[1];
      m_vb_prev   = vblank;
      @(posedge clk_sys);
      #1;
      chk("model_rgb_out", 32'(rgb_out), 32'(m_rgb));
      chk("model_pause_cpu", 32'(pause_cpu), 32'(m_pause));
      chk("model_dim_level", 32'(dim_level), 32'(m_level));
      $display("cyc rst=%0b btn=%0b req=%0b osd=%0b opt=%b vb=%0b rgb_in=%h -> rgb_out=%h pause=%0b lvl=%0d",
               reset, user_button, pause_request, OSD_STATUS, options, vblank, {r, g, b},
               rgb_out, pause_cpu, dim_level);
   endtask

   initial begin
      // reset with full-scale colour on the inputs
      repeat (3) step();
      chk("reset_rgb_zero", 32'(rgb_out), 32'h00);
      chk("reset_pause_zero", 32'(pause_cpu), 32'h0);
      chk("reset_level_zero", 32'(dim_level), 32'h0);
      reset = 1'b0;
      step();
      chk("release_rgb_ff", 32'(rgb_out), 32'hFF);

      // user pause on then off, dim disabled
      user_button = 1'b1;
      step();
      user_button = 1'b0;
      step();
`ifndef PAUSE_FRAME_ALIGN_EN
      chk("button_pause_on", 32'(pause_cpu), 32'h1);
`endif
      user_button = 1'b1;
      step();
      user_button = 1'b0;
      step();
`ifndef PAUSE_FRAME_ALIGN_EN
      chk("button_pause_off", 32'(pause_cpu), 32'h0);
`endif

      // user pause with dim enabled: fade 0 -> 1 -> 2
      options = 2'b10;
      step();
      user_button = 1'b1;
      step();
      user_button = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 18) chk("dim_not_yet", 32'(dim_level), 32'd0);
         if (i == 19) chk("dim_level1", 32'(dim_level), 32'd1);
         if (i == 20) chk("rgb_level1", 32'(rgb_out), 32'b011_011_01);
         if (i == 22) chk("level1_hold", 32'(dim_level), 32'd1);
         if (i == 23) chk("dim_level2", 32'(dim_level), 32'd2);
         if (i == 24) chk("rgb_level2", 32'(rgb_out), 32'b001_001_00);
      end
      chk("dimmed_hold", 32'(dim_level), 32'd2);

      // unpause from DIMMED restores instantly
      user_button = 1'b1;
      step();
      chk("restore_level0", 32'(dim_level), 32'd0);
      user_button = 1'b0;
      step();
      chk("restore_rgb_ff", 32'(rgb_out), 32'hFF);
`ifndef PAUSE_FRAME_ALIGN_EN
      chk("restore_pause_off", 32'(pause_cpu), 32'h0);
`endif

      // external request pauses without dimming; OSD honours options[0]
      pause_request = 1'b1;
      repeat (50) step();
`ifndef PAUSE_FRAME_ALIGN_EN
      chk("request_pause", 32'(pause_cpu), 32'h1);
`endif
      chk("request_no_dim", 32'(dim_level), 32'd0);
      pause_request = 1'b0;
      OSD_STATUS = 1'b1;
      options = 2'b00;
      repeat (3) step();
      chk("osd_masked", 32'(pause_cpu), 32'h0);
      options = 2'b01;
      repeat (2) step();
`ifndef PAUSE_FRAME_ALIGN_EN
      chk("osd_pause", 32'(pause_cpu), 32'h1);
`endif
      OSD_STATUS = 1'b0;
      options = 2'b10;
      repeat (2) step();

      // randomized phase against the model
      for (int n = 0; n < 4000; n++) begin
         r = 3'($urandom);
         g = 3'($urandom);
         b = 2'($urandom);
         if ($urandom_range(0, 99) < 2) user_button = ~user_button;
         if ($urandom_range(0, 99) < 2) pause_request = ~pause_request;
         if ($urandom_range(0, 99) < 3) OSD_STATUS = ~OSD_STATUS;
         if ($urandom_range(0, 99) < 2) options[0] = ~options[0];
         if ($urandom_range(0, 199) < 1) options[1] = ~options[1];
         else if (!options[1] && $urandom_range(0, 9) == 0) options[1] = 1'b1;
         if ($urandom_range(0, 9) == 0) vblank = ~vblank;
         reset = ($urandom_range(0, 999) < 3);
         step();
      end
      reset = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
